// File: rtl/tff_sync_up_counter_pkg.sv
// Shared constants and types for the synchronous T-FF up-counter.
package tff_cnt_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int MOD_DEF   = 16;
  localparam int TERM      = MOD_DEF - 1;

  typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/tff_sync_up_counter_if.sv
// Control/status bundle of the synchronous T-FF up-counter.
interface tff_sync_up_counter_if
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             T;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrap;

  modport master (output T, load, din, input Q, tc, wrap);
  modport slave  (input T, load, din, output Q, tc, wrap);
endinterface

// File: rtl/tff_sync_up_counter_t_ff_sync.sv
// Single synchronous toggle flip-flop with reset and clear.
module t_ff_sync (
  input  logic En,
  input  logic reset,
  input  logic T,
  input  logic clr,
  output logic Q
);
  logic q_q;

  always_ff @(posedge En) begin
    if (reset || clr) q_q <= 1'b0;
    else              q_q <= q_q ^ T;
  end

  assign Q = q_q;
endmodule

// File: rtl/tff_sync_up_counter.sv
// Synchronous modulo-MOD up-counter built from WIDTH toggle flip-flops.
// Define TFF_CNT_SATURATE_EN to hold at MOD-1 instead of wrapping.
module tff_sync_up_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MOD   = MOD_DEF
) (
  input  logic En,
  input  logic reset,
  tff_sync_up_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] TERM_L = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] q, ld_val, tgl;
  logic             at_term, cnt, clr, run;
  logic             wrap_q, wrap_d;

  assign at_term = (q == TERM_L);
  // Out-of-range load values collapse to zero so Q never leaves 0..MOD-1.
  assign ld_val  = ({1'b0, bus.din} < MOD_W) ? bus.din : '0;

`ifdef TFF_CNT_SATURATE_EN
  assign cnt    = bus.T & ~at_term;
  assign clr    = 1'b0;
  assign wrap_d = 1'b0;
`else
  assign cnt    = bus.T;
  assign clr    = ~bus.load & bus.T & at_term;
  assign wrap_d = ~bus.load & bus.T & at_term;
`endif

  // Load is applied by toggling exactly the bits that differ from din.
  always_comb begin
    tgl = '0;
    run = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      tgl[i] = bus.load ? (ld_val[i] ^ q[i]) : run;
      run    = run & q[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_sync u_tff (
      .En   (En),
      .reset(reset),
      .T    (tgl[i]),
      .clr  (clr),
      .Q    (q[i])
    );
  end

  always_ff @(posedge En) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign bus.Q    = q;
  assign bus.tc   = bus.T & at_term;
  assign bus.wrap = wrap_q;
endmodule
